kbd_scan_ctrl: RTL and testbench

- Sequences the intel8042 serial scan-code output for the system side.
- Deserializes each KBD_DATA frame and buffers codes in a small FIFO.
- Presents the FIFO head to the host (8255 port A path) and raises IRQ1 while codes are pending.
- Applies backpressure (KBD_HOLD) and a host-driven clear/flush, the XT PB7 equivalent.

---
 rtl/kbd_pkg.sv | 7 +
 rtl/kbd_scan_ctrl_if.sv | 17 +
 rtl/kbd_scan_fifo.sv | 56 +++++
 rtl/kbd_scan_ctrl.sv | 80 ++++++++
 tb/tb_kbd_scan_ctrl.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared receiver state encoding and scan-code constants
package kbd_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_GAP, ST_DATA, ST_STOP} kbd_state_e;
  localparam int KBD_FRAME_BITS = 8;
  localparam logic [7:0] KBD_OVERRUN_CODE = 8'hFF;
  localparam logic [7:0] KBD_EMPTY_CODE = 8'h00;
endpackage

// File: rtl/kbd_scan_ctrl_if.sv
// kbd_scan_ctrl_if: serial line, host handshake and status bundle
//   master: intel8042/host side (drives KBD_DATA, KBD_CLEAR, HOST_ACK)
//   slave : kbd_scan_ctrl side (drives HOST_DATA, IRQ1, KBD_HOLD, OVERRUN, FRAME_ERR)
interface kbd_scan_ctrl_if;
  logic       KBD_DATA;
  logic       KBD_CLEAR;
  logic       HOST_ACK;
  logic [7:0] HOST_DATA;
  logic       IRQ1;
  logic       KBD_HOLD;
  logic       OVERRUN;
  logic       FRAME_ERR;
  modport master (output KBD_DATA, KBD_CLEAR, HOST_ACK,
                  input  HOST_DATA, IRQ1, KBD_HOLD, OVERRUN, FRAME_ERR);
  modport slave  (input  KBD_DATA, KBD_CLEAR, HOST_ACK,
                  output HOST_DATA, IRQ1, KBD_HOLD, OVERRUN, FRAME_ERR);
endinterface

// File: rtl/kbd_scan_fifo.sv
// kbd_scan_fifo: sync FIFO with registered head output
//   clk/rst_n : clock, async active-low reset
//   i_clr     : synchronous flush
//   i_push/i_pop/i_data : write and read strobes, write data
//   i_ovr     : while full, overwrite the newest entry with i_data
//   o_head    : registered head, empty code when empty; o_full/o_empty status
module kbd_scan_fifo import kbd_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W = KBD_FRAME_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_ovr,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [W-1:0]  r_mem [DEPTH];
  logic [W-1:0]  r_head;
  logic [PW-1:0] r_wr, r_rd, w_wr_n, w_rd_n;
  logic [AW-1:0] w_last;
  logic          w_do_push, w_do_pop;
  assign o_empty   = r_wr == r_rd;
  assign o_full    = r_wr == (r_rd ^ PW'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign w_wr_n    = r_wr + PW'(w_do_push);
  assign w_rd_n    = r_rd + PW'(w_do_pop);
  assign w_last    = r_wr[AW-1:0] - AW'(1);
  assign o_head    = r_head;
  // head is recomputed from next-state pointers so a push into an empty FIFO is visible at once
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= W'(KBD_EMPTY_CODE);
    end else if (i_clr) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_head <= W'(KBD_EMPTY_CODE);
    end else begin
      r_wr   <= w_wr_n;
      r_rd   <= w_rd_n;
      r_head <= (w_wr_n == w_rd_n) ? W'(KBD_EMPTY_CODE) :
                (w_do_push && r_wr[AW-1:0] == w_rd_n[AW-1:0]) ? i_data : r_mem[w_rd_n[AW-1:0]];
    end
  always_ff @(posedge clk)
    if (!i_clr && w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
    else if (!i_clr && i_ovr && o_full) r_mem[w_last] <= i_data;
endmodule

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: intel8042 scan-code deserializer with host FIFO, IRQ1 and backpressure
//   KBD_CLK/KBD_RESET_N : clock, async active-low reset
//   bus (slave)         : KBD_DATA, KBD_CLEAR, HOST_ACK in; HOST_DATA, IRQ1, KBD_HOLD, OVERRUN, FRAME_ERR out
//   KBD_OVERRUN_CODE_EN : when defined, overflow replaces the newest entry with the 8042 overrun code
module kbd_scan_ctrl import kbd_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int BIT0_OFFSET = 2
) (
  input logic KBD_CLK,
  input logic KBD_RESET_N,
  kbd_scan_ctrl_if.slave bus
);
  localparam int GW = $clog2(BIT0_OFFSET + 1);
  kbd_state_e                r_state;
  logic [GW-1:0]             r_gap;
  logic [2:0]                r_idx;
  logic [KBD_FRAME_BITS-1:0] r_byte;
  logic                      r_commit, r_ovr, r_ferr;
  logic                      w_pop, w_full, w_empty, w_overflow, w_ovr_wr;
  logic [KBD_FRAME_BITS-1:0] w_fifo_data, w_head;
  assign w_pop      = bus.HOST_ACK & ~bus.KBD_CLEAR;
  assign w_overflow = r_commit & w_full & ~w_pop;
`ifdef KBD_OVERRUN_CODE_EN
  assign w_ovr_wr    = w_overflow;
  assign w_fifo_data = w_overflow ? KBD_OVERRUN_CODE : r_byte;
`else
  assign w_ovr_wr    = 1'b0;
  assign w_fifo_data = r_byte;
`endif
  kbd_scan_fifo #(.DEPTH(DEPTH), .W(KBD_FRAME_BITS)) u_fifo (
    .clk(KBD_CLK), .rst_n(KBD_RESET_N), .i_clr(bus.KBD_CLEAR), .i_push(r_commit),
    .i_pop(w_pop), .i_ovr(w_ovr_wr), .i_data(w_fifo_data), .o_head(w_head),
    .o_full(w_full), .o_empty(w_empty)
  );
  assign bus.HOST_DATA = w_head;
  assign bus.IRQ1      = ~w_empty & ~bus.KBD_CLEAR;
  assign bus.KBD_HOLD  = w_full | bus.KBD_CLEAR;
  assign bus.OVERRUN   = r_ovr;
  assign bus.FRAME_ERR = r_ferr;
  // gap counter is preloaded so bit 0 lands exactly BIT0_OFFSET edges after the start-bit edge;
  // a completed byte is pushed one edge after the stop slot via r_commit
  always_ff @(posedge KBD_CLK or negedge KBD_RESET_N)
    if (!KBD_RESET_N) begin
      r_state  <= ST_IDLE;
      r_gap    <= '0;
      r_idx    <= '0;
      r_byte   <= '0;
      r_commit <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else if (bus.KBD_CLEAR) begin
      r_state  <= ST_IDLE;
      r_commit <= 1'b0;
      r_ovr    <= 1'b0;
      r_ferr   <= 1'b0;
    end else begin
      r_commit <= 1'b0;
      if (w_overflow) r_ovr <= 1'b1;
      case (r_state)
        ST_IDLE: if (!bus.KBD_DATA) begin
          r_state <= (BIT0_OFFSET == 1) ? ST_DATA : ST_GAP;
          r_gap   <= GW'(BIT0_OFFSET - 2);
          r_idx   <= '0;
        end
        ST_GAP: if (r_gap == '0) r_state <= ST_DATA;
                else r_gap <= r_gap - GW'(1);
        ST_DATA: begin
          r_byte[r_idx] <= bus.KBD_DATA;
          r_idx         <= r_idx + 3'd1;
          if (r_idx == 3'(KBD_FRAME_BITS - 1)) r_state <= ST_STOP;
        end
        ST_STOP: begin
          r_state <= ST_IDLE;
          if (bus.KBD_DATA) r_commit <= 1'b1;
          else r_ferr <= 1'b1;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: randomized and directed checks of kbd_scan_ctrl against a queue model
module tb_kbd_scan_ctrl;
  import kbd_pkg::*;
  localparam int DEPTH = 4;
  localparam int OFF = 2;
  typedef struct {int t; logic [7:0] b;} commit_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  kbd_scan_ctrl_if bus();
  kbd_scan_ctrl #(.DEPTH(DEPTH), .BIT0_OFFSET(OFF)) dut (
    .KBD_CLK(clk), .KBD_RESET_N(rst_n), .bus(bus)
  );
  always #5 clk = ~clk;
  commit_t    pend[$];
  int         ferr_q[$];
  logic [7:0] q[$];
  bit         m_ovr = 0, m_ferr = 0, m_pop;
  logic [7:0] m_b;
  int         m_e;
  int         cyc = 0, n_tests = 0, n_fail = 0, last_t = 0, last_ferr_t = 0, ack_at = -1;
  bit         rand_ack = 0, chk_on = 0;
  logic [7:0] fb [5];
  function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, exp, cyc);
    end
  endfunction
  always @(posedge clk) cyc <= cyc + 1;
  // model: a committed byte enters the queue OFF+9 edges after its start-bit edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete(); pend.delete(); ferr_q.delete(); m_ovr = 0; m_ferr = 0;
    end else if (bus.KBD_CLEAR) begin
      q.delete(); pend.delete(); ferr_q.delete(); m_ovr = 0; m_ferr = 0;
    end else begin
      m_e = cyc + 1;
      m_pop = bus.HOST_ACK && q.size() > 0;
      if (ferr_q.size() > 0 && ferr_q[0] == m_e) begin
        void'(ferr_q.pop_front());
        m_ferr = 1;
      end
      if (pend.size() > 0 && pend[0].t == m_e) begin
        m_b = pend[0].b;
        void'(pend.pop_front());
        if (q.size() == DEPTH && !m_pop) begin
          m_ovr = 1;
`ifdef KBD_OVERRUN_CODE_EN
          q[DEPTH-1] = 8'hFF;
`endif
        end else q.push_back(m_b);
      end
      if (m_pop) void'(q.pop_front());
    end
  end
  always @(negedge clk)
    if (rst_n && chk_on) begin
      check("head", bus.HOST_DATA, q.size() > 0 ? q[0] : 8'h00);
      check("irq1", 8'(bus.IRQ1), 8'(q.size() > 0 && !bus.KBD_CLEAR));
      check("hold", 8'(bus.KBD_HOLD), 8'(q.size() == DEPTH || bus.KBD_CLEAR));
      check("overrun", 8'(bus.OVERRUN), 8'(m_ovr));
      check("frame_err", 8'(bus.FRAME_ERR), 8'(m_ferr));
    end
  always @(negedge clk) bus.HOST_ACK = (cyc + 1 == ack_at) || (rand_ack && $urandom_range(0, 3) == 0);
  task automatic drive(logic v);
    @(posedge clk); #1; bus.KBD_DATA = v;
  endtask
  task automatic send_frame(logic [7:0] b, bit ok);
    @(posedge clk); #1;
    bus.KBD_DATA = 1'b0;
    last_t = cyc + 1 + OFF + 9;
    last_ferr_t = cyc + 1 + OFF + 8;
    if (ok) pend.push_back('{t: last_t, b: b});
    else ferr_q.push_back(last_ferr_t);
    repeat (OFF - 1) drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
    drive(ok);
  endtask
  task automatic partial(int nb);
    @(posedge clk); #1; bus.KBD_DATA = 1'b0;
    repeat (OFF - 1) drive(1'b0);
    for (int i = 0; i < nb; i++) drive(1'($urandom_range(0, 1)));
  endtask
  task automatic idle(int n);
    repeat (n) drive(1'b1);
  endtask
  task automatic at_edge(int t);
    do @(negedge clk); while (cyc < t);
  endtask
  task automatic ack_one();
    @(posedge clk); #1; ack_at = cyc + 1;
    @(posedge clk); #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end
  initial begin
    bus.KBD_DATA = 1'b1; bus.KBD_CLEAR = 1'b0;
    fb = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1; chk_on = 1;
    @(negedge clk);
    check("rst_head", bus.HOST_DATA, 8'h00);
    check("rst_irq1", 8'(bus.IRQ1), 8'h00);
    check("rst_hold", 8'(bus.KBD_HOLD), 8'h00);
    check("rst_ovr", 8'(bus.OVERRUN), 8'h00);
    check("rst_ferr", 8'(bus.FRAME_ERR), 8'h00);
    send_frame(8'h1E, 1);
    at_edge(last_t - 1);
    check("lat_irq_early", 8'(bus.IRQ1), 8'h00);
    at_edge(last_t);
    check("lat_head", bus.HOST_DATA, 8'h1E);
    check("lat_irq", 8'(bus.IRQ1), 8'h01);
    ack_one(); @(negedge clk);
    check("ack_head", bus.HOST_DATA, 8'h00);
    check("ack_irq", 8'(bus.IRQ1), 8'h00);
    send_frame(8'h01, 1); send_frame(8'h9E, 1); send_frame(8'hAA, 1);
    at_edge(last_t);
    check("b2b_head0", bus.HOST_DATA, 8'h01);
    ack_one(); @(negedge clk); check("b2b_head1", bus.HOST_DATA, 8'h9E);
    ack_one(); @(negedge clk); check("b2b_head2", bus.HOST_DATA, 8'hAA);
    check("b2b_irq_held", 8'(bus.IRQ1), 8'h01);
    ack_one(); @(negedge clk); check("b2b_irq_drop", 8'(bus.IRQ1), 8'h00);
    for (int i = 0; i < 4; i++) send_frame(fb[i], 1);
    at_edge(last_t);
    check("full_hold", 8'(bus.KBD_HOLD), 8'h01);
    check("full_no_ovr", 8'(bus.OVERRUN), 8'h00);
    send_frame(fb[4], 1);
    at_edge(last_t);
    check("ovr_set", 8'(bus.OVERRUN), 8'h01);
    for (int i = 0; i < 4; i++) begin
`ifdef KBD_OVERRUN_CODE_EN
      check("ovr_order", bus.HOST_DATA, i == 3 ? 8'hFF : fb[i]);
`else
      check("ovr_order", bus.HOST_DATA, fb[i]);
`endif
      ack_one(); @(negedge clk);
    end
    check("ovr_drained", 8'(bus.IRQ1), 8'h00);
    check("ovr_sticky", 8'(bus.OVERRUN), 8'h01);
    send_frame(8'h77, 1); send_frame(8'h55, 0); idle(2);
    at_edge(last_ferr_t);
    check("ferr_set", 8'(bus.FRAME_ERR), 8'h01);
    check("ferr_head", bus.HOST_DATA, 8'h77);
    check("ferr_irq", 8'(bus.IRQ1), 8'h01);
    send_frame(8'h12, 1);
    partial(4);
    @(posedge clk); #1; bus.KBD_DATA = 1'b1; bus.KBD_CLEAR = 1'b1;
    @(negedge clk);
    check("clr_irq_mask", 8'(bus.IRQ1), 8'h00);
    check("clr_hold", 8'(bus.KBD_HOLD), 8'h01);
    @(posedge clk); #1; bus.KBD_CLEAR = 1'b0;
    @(negedge clk);
    check("clr_head", bus.HOST_DATA, 8'h00);
    check("clr_ovr", 8'(bus.OVERRUN), 8'h00);
    check("clr_ferr", 8'(bus.FRAME_ERR), 8'h00);
    send_frame(8'h3B, 1);
    at_edge(last_t);
    check("post_clr_head", bus.HOST_DATA, 8'h3B);
    ack_one();
    for (int i = 0; i < 4; i++) send_frame(8'hA0 + 8'(i), 1);
    send_frame(8'hA4, 1);
    ack_at = last_t;
    at_edge(last_t);
    check("same_ovr", 8'(bus.OVERRUN), 8'h00);
    check("same_hold", 8'(bus.KBD_HOLD), 8'h01);
    for (int i = 1; i < 5; i++) begin
      check("same_order", bus.HOST_DATA, 8'hA0 + 8'(i));
      ack_one(); @(negedge clk);
    end
    check("same_empty", bus.HOST_DATA, 8'h00);
    rand_ack = 1;
    for (int n = 0; n < 40; n++) begin
      automatic bit ok = $urandom_range(0, 5) != 0;
      send_frame(8'($urandom), ok);
      idle(ok ? $urandom_range(0, 2) : $urandom_range(1, 3));
    end
    rand_ack = 0;
    idle(3);
    repeat (DEPTH + 1) ack_one();
    send_frame(8'h66, 1);
    at_edge(last_t);
    partial(3);
    @(posedge clk); #1; rst_n = 1'b0; bus.KBD_DATA = 1'b1;
    #2;
    check("arst_head", bus.HOST_DATA, 8'h00);
    check("arst_irq", 8'(bus.IRQ1), 8'h00);
    check("arst_ovr", 8'(bus.OVERRUN), 8'h00);
    check("arst_ferr", 8'(bus.FRAME_ERR), 8'h00);
    @(posedge clk); #1; rst_n = 1'b1;
    send_frame(8'h5A, 1);
    at_edge(last_t);
    check("arst_next", bus.HOST_DATA, 8'h5A);
    idle(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
